// File: rtl/interrupt_pkg.sv
// Shared constants for the interrupt arbiter: one-hot FSM encoding and the default issue timeout.
package interrupt_pkg;

    localparam logic [2:0] IA_IDLE  = 3'b001;
    localparam logic [2:0] IA_ISSUE = 3'b010;
    localparam logic [2:0] IA_GAP   = 3'b100;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_select #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [NREQ-1:0] rot;
    int unsigned     sum;

    always_comb begin
        // Rotate so that bit 0 of rot is the requester the pointer names.
        rot     = NREQ'({req_i, req_i} >> ptr_i);
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rot[i] && !valid_o) begin
                valid_o = 1'b1;
                sum     = 32'(ptr_i) + i;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                idx_o = IDW'(sum);
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Round-robin sharing of the endpoint cfg_interrupt handshake with a minimum post-interrupt gap.
// Define INTERRUPT_ARBITER_TIMEOUT_EN to abort an unanswered issue after TIMEOUT_CYCLES.
module interrupt_arbiter
    import interrupt_pkg::*;
#(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned IDW            = 3,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] int_req,
    output logic [NREQ-1:0] int_ack,
    output logic            cfg_interrupt_n,
    input  logic            cfg_interrupt_rdy_n,
    input  logic            interrupts_enabled,
    input  logic [31:0]     min_gap,
    output logic [IDW-1:0]  grant_id
`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
    ,
    output logic            timeout_err
`endif
);

    logic [2:0]      state_q, state_d;
    logic            cint_n_q, cint_n_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [31:0]     gap_q, gap_d;
    logic [31:0]     gap_lim_q, gap_lim_d;

    logic [IDW-1:0]  sel_idx;
    logic            sel_valid;
    logic [IDW-1:0]  next_ptr;
    logic            issue_done;

    rr_select #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_select (
        .req_i   (int_req),
        .ptr_i   (ptr_q),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    assign next_ptr = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] to_q, to_d;
    logic        to_hit;
    logic        timeout_q;

    assign to_hit     = (state_q == IA_ISSUE) && cfg_interrupt_rdy_n && (to_q == TO_LAST);
    assign to_d       = (state_q == IA_ISSUE) ? to_q + 32'd1 : 32'd0;
    assign issue_done = !cfg_interrupt_rdy_n || to_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_q      <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            to_q      <= to_d;
            timeout_q <= to_hit;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign issue_done     = !cfg_interrupt_rdy_n;
`endif

    always_comb begin
        state_d   = state_q;
        cint_n_d  = cint_n_q;
        ack_d     = '0;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        gap_lim_d = gap_lim_q;
        unique case (state_q)
            IA_IDLE: begin
                if (interrupts_enabled && sel_valid) begin
                    grant_d  = sel_idx;
                    cint_n_d = 1'b0;
                    state_d  = IA_ISSUE;
                end
            end
            IA_ISSUE: begin
                // Aborting on timeout shares the completion path but never acks.
                if (issue_done) begin
                    cint_n_d  = 1'b1;
                    ptr_d     = next_ptr;
                    gap_lim_d = min_gap;
                    gap_d     = 32'd0;
                    state_d   = IA_GAP;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        ack_d[i] = !cfg_interrupt_rdy_n && (grant_q == IDW'(i));
                    end
                end
            end
            IA_GAP: begin
                if (gap_q == gap_lim_q) begin
                    state_d = IA_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: begin
                state_d  = IA_IDLE;
                cint_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IA_IDLE;
            cint_n_q  <= 1'b1;
            ack_q     <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            gap_q     <= 32'd0;
            gap_lim_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cint_n_q  <= cint_n_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            gap_lim_q <= gap_lim_d;
        end
    end

    assign cfg_interrupt_n = cint_n_q;
    assign int_ack         = ack_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter; covers the timeout path when
// INTERRUPT_ARBITER_TIMEOUT_EN is defined.
module tb_interrupt_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  int_req;
    logic [1:0]  int_ack;
    logic        cfg_interrupt_n;
    logic        cfg_interrupt_rdy_n;
    logic        interrupts_enabled;
    logic [31:0] min_gap;
    logic [2:0]  grant_id;
`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    interrupt_arbiter #(
        .NREQ (2),
        .IDW  (3)
`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .int_req             (int_req),
        .int_ack             (int_ack),
        .cfg_interrupt_n     (cfg_interrupt_n),
        .cfg_interrupt_rdy_n (cfg_interrupt_rdy_n),
        .interrupts_enabled  (interrupts_enabled),
        .min_gap             (min_gap),
        .grant_id            (grant_id)
`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
        ,
        .timeout_err         (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles until cfg_interrupt_n is seen low, bounded at 50.
    task automatic wait_issue(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cfg_interrupt_n !== 1'b0 && n < 50);
    endtask

    int n;
    int cnt;
    int exp_id [4] = '{0, 1, 0, 1};

    initial begin
        reset_n             = 1'b0;
        int_req             = 2'b00;
        cfg_interrupt_rdy_n = 1'b1;
        interrupts_enabled  = 1'b0;
        min_gap             = 32'd0;
        tick();
        tick();
        check("rst_cint_n", 32'(cfg_interrupt_n), 32'd1);
        check("rst_ack", 32'(int_ack), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
        check("rst_timeout", 32'(timeout_err), 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        // Single requester, endpoint answers 3 cycles after the issue.
        interrupts_enabled = 1'b1;
        min_gap            = 32'd4;
        int_req            = 2'b01;
        tick();
        check("single_issue", 32'(cfg_interrupt_n), 32'd0);
        check("single_grant", 32'(grant_id), 32'd0);
        tick();
        tick();
        check("single_hold", 32'(cfg_interrupt_n), 32'd0);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("single_ack", 32'(int_ack), 32'd1);
        check("single_release", 32'(cfg_interrupt_n), 32'd1);
        cfg_interrupt_rdy_n = 1'b1;
        tick();
        check("single_ack_pulse", 32'(int_ack), 32'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cfg_interrupt_n === 1'b0) cnt++;
        end
        check("single_gap_quiet", 32'(cnt), 32'd0);
        tick();
        check("single_regrant", 32'(cfg_interrupt_n), 32'd0);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("single_ack2", 32'(int_ack), 32'd1);
        cfg_interrupt_rdy_n = 1'b1;
        int_req             = 2'b00;

        // Reset restores the pointer so the round-robin sequence starts at 0.
        reset_n = 1'b0;
        tick();
        check("rst2_cint_n", 32'(cfg_interrupt_n), 32'd1);
        reset_n = 1'b1;
        tick();

        min_gap = 32'd0;
        int_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_issue(n);
            check("rr_latency", 32'(n), (k == 0) ? 32'd1 : 32'd2);
            check("rr_grant", 32'(grant_id), 32'(exp_id[k]));
            cfg_interrupt_rdy_n = 1'b0;
            tick();
            check("rr_ack", 32'(int_ack), 32'd1 << exp_id[k]);
            cfg_interrupt_rdy_n = 1'b1;
        end
        int_req = 2'b00;
        tick();
        tick();
        tick();

        // Disable gating.
        interrupts_enabled = 1'b0;
        int_req            = 2'b10;
        cnt                = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cfg_interrupt_n === 1'b0 || int_ack !== 2'b00) cnt++;
        end
        check("dis_quiet", 32'(cnt), 32'd0);
        interrupts_enabled = 1'b1;
        wait_issue(n);
        check("dis_enable_lat", 32'(n), 32'd1);
        check("dis_grant", 32'(grant_id), 32'd1);
        interrupts_enabled = 1'b0;
        tick();
        tick();
        check("dis_issue_hold", 32'(cfg_interrupt_n), 32'd0);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("dis_issue_ack", 32'(int_ack), 32'd2);
        check("dis_issue_release", 32'(cfg_interrupt_n), 32'd1);
        cfg_interrupt_rdy_n = 1'b1;
        int_req             = 2'b00;
        interrupts_enabled  = 1'b1;

        // Gap latch: 10 latched at the ack, later change to 2 ignored.
        min_gap = 32'd10;
        int_req = 2'b01;
        wait_issue(n);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("gap_ack", 32'(int_ack), 32'd1);
        cfg_interrupt_rdy_n = 1'b1;
        min_gap             = 32'd2;
        wait_issue(n);
        check("gap_len", 32'(n), 32'd12);
        check("gap_grant", 32'(grant_id), 32'd0);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("gap_ack2", 32'(int_ack), 32'd1);
        cfg_interrupt_rdy_n = 1'b1;
        int_req             = 2'b00;

        // Asynchronous reset in the middle of an issue.
        int_req = 2'b10;
        wait_issue(n);
        check("arst_pre_issue", 32'(cfg_interrupt_n), 32'd0);
        check("arst_pre_grant", 32'(grant_id), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cint_n", 32'(cfg_interrupt_n), 32'd1);
        check("arst_ack", 32'(int_ack), 32'd0);
        check("arst_grant", 32'(grant_id), 32'd0);
        int_req = 2'b00;
        tick();
        reset_n = 1'b1;
        tick();
        check("arst_idle", 32'(cfg_interrupt_n), 32'd1);
        int_req = 2'b10;
        tick();
        check("arst_reissue", 32'(cfg_interrupt_n), 32'd0);
        check("arst_regrant", 32'(grant_id), 32'd1);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("arst_ack2", 32'(int_ack), 32'd2);
        cfg_interrupt_rdy_n = 1'b1;
        int_req             = 2'b00;

`ifdef INTERRUPT_ARBITER_TIMEOUT_EN
        // Endpoint never answers: abort after 16 issue cycles, retry after the gap.
        min_gap = 32'd3;
        tick();
        tick();
        tick();
        int_req = 2'b01;
        wait_issue(n);
        n = 0;
        do begin
            tick();
            n++;
        end while (timeout_err !== 1'b1 && n < 40);
        check("to_cycles", 32'(n), 32'd16);
        check("to_no_ack", 32'(int_ack), 32'd0);
        check("to_release", 32'(cfg_interrupt_n), 32'd1);
        tick();
        check("to_pulse", 32'(timeout_err), 32'd0);
        wait_issue(n);
        check("to_retry_lat", 32'(n), 32'd4);
        check("to_retry_grant", 32'(grant_id), 32'd0);
        cfg_interrupt_rdy_n = 1'b0;
        tick();
        check("to_retry_ack", 32'(int_ack), 32'd1);
        cfg_interrupt_rdy_n = 1'b1;
        int_req             = 2'b00;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
